// File: rtl/digit_counter_multi.sv
// Multi-digit BASE-radix up/down counter driven by two active-low push buttons, with a multiplexed display scanner.
// Optional auto-repeat on held buttons is enabled by defining DIGIT_COUNTER_AUTOREPEAT_EN.
module digit_counter_multi #(
    parameter int DIGITS        = 4,
    parameter int BASE          = 10,
    parameter int WRAP          = 1,
    parameter int SCAN_DIV      = 1000,
    parameter int REPEAT_DELAY  = 500000,
    parameter int REPEAT_PERIOD = 100000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  button_increase,
    input  logic                  button_decrease,
    output logic [4*DIGITS-1:0]   value,
    output logic [3:0]            digit,
    output logic [DIGITS-1:0]     digit_select,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int         DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int         IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [3:0] DMAX  = 4'(BASE - 1);

    if (DIGITS < 1 || DIGITS > 8 || BASE < 2 || BASE > 10 || SCAN_DIV < 1 ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("digit_counter_multi: illegal parameter value");
    end

    // Button bit 0 = increase, bit 1 = decrease.
    logic [1:0] sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [1:0] armed_q, armed_d, settle_q, settle_d;
    logic [1:0] press, held, ev;

    logic [DIGITS-1:0][3:0] value_q, value_d, inc_v, dec_v;
    logic                   carry, borrow;
    logic                   overflow_q, overflow_d, underflow_q, underflow_d;
    logic [DIV_W-1:0]       div_q, div_d;
    logic [IDX_W-1:0]       idx_q, idx_d;

    // A button held through reset must be seen released once before it can
    // fire; armed only sets after the synchronizer holds real input samples.
    always_comb begin
        sync1_d  = {button_decrease, button_increase};
        sync2_d  = sync1_q;
        prev_d   = sync2_q;
        settle_d = {settle_q[0], 1'b1};
        armed_d  = armed_q | ({2{settle_q[1]}} & sync2_q);
        press    = armed_q & prev_q & ~sync2_q;
        held     = armed_q & ~prev_q & ~sync2_q;
    end

`ifdef DIGIT_COUNTER_AUTOREPEAT_EN
    logic [1:0][31:0] rpt_cnt_q, rpt_cnt_d;
    logic [1:0]       rpt_on_q, rpt_on_d, rpt_fire;

    // Counter restarts at every event; the first repeat uses the delay, later ones the period.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            rpt_cnt_d[b] = '0;
            rpt_on_d[b]  = 1'b0;
            rpt_fire[b]  = 1'b0;
            if (held[b]) begin
                rpt_fire[b]  = rpt_on_q[b] ? (rpt_cnt_q[b] == 32'(REPEAT_PERIOD - 1))
                                           : (rpt_cnt_q[b] == 32'(REPEAT_DELAY - 1));
                rpt_on_d[b]  = rpt_on_q[b] | rpt_fire[b];
                rpt_cnt_d[b] = rpt_fire[b] ? '0 : rpt_cnt_q[b] + 32'd1;
            end
        end
        ev = press | rpt_fire;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rpt_cnt_q <= '0;
            rpt_on_q  <= '0;
        end else begin
            rpt_cnt_q <= rpt_cnt_d;
            rpt_on_q  <= rpt_on_d;
        end
    end
`else
    assign ev = press;
`endif

    // Full ripple carry/borrow across all digits in one cycle; final carry
    // or borrow out means the counter sat at its limit.
    always_comb begin
        inc_v  = value_q;
        dec_v  = value_q;
        carry  = 1'b1;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (value_q[i] >= DMAX) begin
                    inc_v[i] = '0;
                end else begin
                    inc_v[i] = value_q[i] + 4'd1;
                    carry    = 1'b0;
                end
            end
            if (borrow) begin
                if (value_q[i] == 4'd0) begin
                    dec_v[i] = DMAX;
                end else begin
                    dec_v[i] = (value_q[i] > DMAX) ? DMAX : value_q[i] - 4'd1;
                    borrow   = 1'b0;
                end
            end
        end

        value_d     = value_q;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        if (ev[0] && !ev[1]) begin
            overflow_d = carry;
            value_d    = (carry && WRAP == 0) ? value_q : inc_v;
        end else if (ev[1] && !ev[0]) begin
            underflow_d = borrow;
            value_d     = (borrow && WRAP == 0) ? value_q : dec_v;
        end
    end

    always_comb begin
        div_d = div_q + DIV_W'(1);
        idx_d = idx_q;
        if (div_q == DIV_W'(SCAN_DIV - 1)) begin
            div_d = '0;
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q     <= 2'b11;
            sync2_q     <= 2'b11;
            prev_q      <= 2'b11;
            armed_q     <= 2'b00;
            settle_q    <= 2'b00;
            value_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            div_q       <= '0;
            idx_q       <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            prev_q      <= prev_d;
            armed_q     <= armed_d;
            settle_q    <= settle_d;
            value_q     <= value_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            div_q       <= div_d;
            idx_q       <= idx_d;
        end
    end

    assign value        = value_q;
    assign digit        = value_q[idx_q];
    assign digit_select = DIGITS'(1) << idx_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_digit_counter_multi.sv
// Directed bench for digit_counter_multi: a wrapping and a saturating instance share the same button stimulus.
module tb_digit_counter_multi;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        binc  = 1'b1;
    logic        bdec  = 1'b1;
    logic [15:0] val_w, val_s;
    logic [3:0]  dig_w, dig_s, sel_w, sel_s;
    logic        ovf_w, ovf_s, unf_w, unf_s;
    int          nvec = 0;
    int          nerr = 0;
    int          cyc  = 0;

    digit_counter_multi #(.DIGITS(4), .BASE(10), .WRAP(1), .SCAN_DIV(4),
                          .REPEAT_DELAY(10), .REPEAT_PERIOD(5)) dut (
        .clock(clock), .reset(reset), .button_increase(binc), .button_decrease(bdec),
        .value(val_w), .digit(dig_w), .digit_select(sel_w), .overflow(ovf_w), .underflow(unf_w));

    digit_counter_multi #(.DIGITS(4), .BASE(10), .WRAP(0), .SCAN_DIV(4),
                          .REPEAT_DELAY(10), .REPEAT_PERIOD(5)) dut_sat (
        .clock(clock), .reset(reset), .button_increase(binc), .button_decrease(bdec),
        .value(val_s), .digit(dig_s), .digit_select(sel_s), .overflow(ovf_s), .underflow(unf_s));

    always #5 clock = ~clock;

    // Edges since the last reset edge; the scanner position is a pure function of this.
    always @(posedge clock) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1; tick(2); reset = 1'b0; tick(4);
    endtask

    // Two-cycle press/release pulses; each yields one event.
    task automatic fast_press(input bit inc, input int n);
        repeat (n) begin
            if (inc) binc = 1'b0; else bdec = 1'b0;
            tick();
            binc = 1'b1; bdec = 1'b1;
            tick();
        end
        tick(4);
    endtask

    task automatic test_reset();
        reset = 1'b1; binc = 1'b1; bdec = 1'b1;
        tick(2);
        nvec++; if (val_w !== 16'h0000 || val_s !== 16'h0000) begin nerr++; $display("FAIL reset_value got %h/%h want 0000", val_w, val_s); end
        nvec++; if ({ovf_w, unf_w, ovf_s, unf_s} !== 4'b0000) begin nerr++; $display("FAIL reset_flags got %b want 0000", {ovf_w, unf_w, ovf_s, unf_s}); end
        nvec++; if (sel_w !== 4'b0001 || sel_s !== 4'b0001) begin nerr++; $display("FAIL reset_select got %b/%b want 0001", sel_w, sel_s); end
        nvec++; if (dig_w !== 4'h0) begin nerr++; $display("FAIL reset_digit got %h want 0", dig_w); end
        reset = 1'b0; tick(4);
    endtask

    task automatic test_increment();
        for (int k = 1; k <= 3; k++) begin
            binc = 1'b0; tick(2);
            nvec++; if (val_w !== 16'(k - 1)) begin nerr++; $display("FAIL inc_edge2_%0d got %h want %h", k, val_w, 16'(k - 1)); end
            binc = 1'b1; tick();
            nvec++; if (val_w !== 16'(k) || val_s !== 16'(k)) begin nerr++; $display("FAIL inc_edge3_%0d got %h/%h want %h", k, val_w, val_s, 16'(k)); end
            nvec++; if ({ovf_w, unf_w} !== 2'b00) begin nerr++; $display("FAIL inc_flags_%0d got %b want 00", k, {ovf_w, unf_w}); end
            tick(2);
        end
    endtask

    task automatic test_cancel();
        fast_press(1'b1, 2);
        nvec++; if (val_w !== 16'h0005) begin nerr++; $display("FAIL preload_5 got %h want 0005", val_w); end
        binc = 1'b0; bdec = 1'b0; tick();
        binc = 1'b1; bdec = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            nvec++; if ({ovf_w, unf_w, ovf_s, unf_s} !== 4'b0000) begin nerr++; $display("FAIL cancel_flags_%0d got %b want 0000", i, {ovf_w, unf_w, ovf_s, unf_s}); end
        end
        nvec++; if (val_w !== 16'h0005 || val_s !== 16'h0005) begin nerr++; $display("FAIL cancel_value got %h/%h want 0005", val_w, val_s); end
    endtask

    task automatic test_reset_hold();
        reset = 1'b1; binc = 1'b0; tick(2);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            nvec++; if (val_w !== 16'h0000) begin nerr++; $display("FAIL hold_reset_%0d got %h want 0000", i, val_w); end
        end
        binc = 1'b1; tick(4);
        nvec++; if (val_w !== 16'h0000) begin nerr++; $display("FAIL hold_release got %h want 0000", val_w); end
        fast_press(1'b1, 1);
        nvec++; if (val_w !== 16'h0001) begin nerr++; $display("FAIL hold_repress got %h want 0001", val_w); end
    endtask

    task automatic test_underflow();
        do_reset();
        bdec = 1'b0; tick(2);
        nvec++; if (unf_w !== 1'b0 || val_w !== 16'h0000) begin nerr++; $display("FAIL unf_early got %b %h want 0 0000", unf_w, val_w); end
        bdec = 1'b1; tick();
        nvec++; if (val_w !== 16'h9999) begin nerr++; $display("FAIL unf_wrap_value got %h want 9999", val_w); end
        nvec++; if (val_s !== 16'h0000) begin nerr++; $display("FAIL unf_sat_value got %h want 0000", val_s); end
        nvec++; if (unf_w !== 1'b1 || unf_s !== 1'b1) begin nerr++; $display("FAIL unf_pulse got %b/%b want 1/1", unf_w, unf_s); end
        tick();
        nvec++; if (unf_w !== 1'b0 || unf_s !== 1'b0 || val_w !== 16'h9999) begin nerr++; $display("FAIL unf_single got %b/%b %h want 0/0 9999", unf_w, unf_s, val_w); end
        tick(2);
    endtask

    task automatic test_overflow_wrap();
        binc = 1'b0; tick(2); binc = 1'b1; tick();
        nvec++; if (val_w !== 16'h0000 || ovf_w !== 1'b1) begin nerr++; $display("FAIL ovf_wrap got %h %b want 0000 1", val_w, ovf_w); end
        nvec++; if (val_s !== 16'h0001 || ovf_s !== 1'b0) begin nerr++; $display("FAIL ovf_wrap_other got %h %b want 0001 0", val_s, ovf_s); end
        tick();
        nvec++; if (ovf_w !== 1'b0) begin nerr++; $display("FAIL ovf_wrap_single got %b want 0", ovf_w); end
        tick(2);
    endtask

    task automatic test_carry();
        do_reset();
        fast_press(1'b1, 999);
        nvec++; if (val_w !== 16'h0999 || val_s !== 16'h0999) begin nerr++; $display("FAIL preload_0999 got %h/%h want 0999", val_w, val_s); end
        binc = 1'b0; tick(2); binc = 1'b1; tick();
        nvec++; if (val_w !== 16'h1000 || val_s !== 16'h1000) begin nerr++; $display("FAIL ripple_carry got %h/%h want 1000", val_w, val_s); end
        tick(2);
    endtask

    task automatic test_overflow_sat();
        fast_press(1'b1, 8999);
        nvec++; if (val_w !== 16'h9999 || val_s !== 16'h9999) begin nerr++; $display("FAIL preload_9999 got %h/%h want 9999", val_w, val_s); end
        binc = 1'b0; tick(2); binc = 1'b1; tick();
        nvec++; if (val_w !== 16'h0000 || ovf_w !== 1'b1) begin nerr++; $display("FAIL ovf_w got %h %b want 0000 1", val_w, ovf_w); end
        nvec++; if (val_s !== 16'h9999 || ovf_s !== 1'b1) begin nerr++; $display("FAIL ovf_sat got %h %b want 9999 1", val_s, ovf_s); end
        tick();
        nvec++; if (ovf_w !== 1'b0 || ovf_s !== 1'b0 || val_s !== 16'h9999) begin nerr++; $display("FAIL ovf_sat_single got %b/%b %h want 0/0 9999", ovf_w, ovf_s, val_s); end
        tick(2);
    endtask

    task automatic test_scan();
        logic [3:0] exp_sel;
        int         idx;
        do_reset();
        fast_press(1'b1, 4321);
        nvec++; if (val_w !== 16'h4321) begin nerr++; $display("FAIL preload_4321 got %h want 4321", val_w); end
        for (int i = 0; i < 16 && (cyc % 16) != 0; i++) tick();
        for (int i = 0; i < 16; i++) begin
            idx     = (cyc / 4) % 4;
            exp_sel = 4'b0001 << idx;
            nvec++; if (sel_w !== exp_sel) begin nerr++; $display("FAIL scan_sel_%0d got %b want %b", i, sel_w, exp_sel); end
            nvec++; if (dig_w !== 4'(idx + 1)) begin nerr++; $display("FAIL scan_digit_%0d got %h want %h", i, dig_w, 4'(idx + 1)); end
            tick();
        end
    endtask

    task automatic test_hold();
        logic [15:0] exp;
`ifdef DIGIT_COUNTER_AUTOREPEAT_EN
        exp = 16'h4325;
`else
        exp = 16'h4322;
`endif
        binc = 1'b0; tick(25); binc = 1'b1; tick(6);
        nvec++; if (val_w !== exp) begin nerr++; $display("FAIL hold_25 got %h want %h", val_w, exp); end
    endtask

    initial begin
        test_reset();
        test_increment();
        test_cancel();
        test_reset_hold();
        test_underflow();
        test_overflow_wrap();
        test_carry();
        test_overflow_sat();
        test_scan();
        test_hold();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/digit_counter_multi.md
DIGIT_COUNTER_MULTI -- requirements
Module: digit_counter_multi

Interface
REQ-001 Parameter DIGITS, default 4, number of counter digits; legal range 1..8.
REQ-002 Parameter BASE, default 10, radix of every digit; legal range 2..10.
REQ-003 Parameter WRAP, default 1; 1 = wrap at limits, 0 = saturate at limits.
REQ-004 Parameter SCAN_DIV, default 1000, clock cycles per display scan step; minimum 1.
REQ-005 Parameter REPEAT_DELAY, default 500000, cycles of hold before auto-repeat starts; used only with REQ-027.
REQ-006 Parameter REPEAT_PERIOD, default 100000, cycles between auto-repeat events; used only with REQ-027.
REQ-007 clock  input  1  single clock; all state changes on its rising edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 button_increase  input  1  raw asynchronous button level, active-low (0 = pressed).
REQ-010 button_decrease  input  1  raw asynchronous button level, active-low (0 = pressed).
REQ-011 value  output  4*DIGITS  registered digit values; digit i occupies bits [4i+3:4i]; digit 0 is least significant.
REQ-012 digit  output  4  value of the digit currently selected by the scanner.
REQ-013 digit_select  output  DIGITS  one-hot select of the scanned digit; bit i selects digit i.
REQ-014 overflow  output  1  single-cycle pulse when an increment is attempted at the maximum value.
REQ-015 underflow  output  1  single-cycle pulse when a decrement is attempted at zero.

Function
REQ-016 Each button SHALL pass through a two-flop synchronizer followed by a previous-level register; a press event is a 1->0 transition of the synchronized level.
REQ-017 Latency: the edge that first samples a raw 0 is edge 1; value SHALL update on edge 3.
REQ-018 Increment: digit 0 +1; a digit at BASE-1 becomes 0 and carries +1 into the next digit, through all digits in the same cycle.
REQ-019 Decrement: digit 0 -1; a digit at 0 becomes BASE-1 and borrows from the next digit, through all digits in the same cycle.
REQ-020 Increment at all digits = BASE-1: WRAP=1 gives all zeros; WRAP=0 holds the value; overflow is 1 for exactly that cycle in both modes.
REQ-021 Decrement at all zeros: WRAP=1 gives all digits = BASE-1; WRAP=0 holds zero; underflow is 1 for exactly that cycle in both modes.
REQ-022 Increment and decrement events in the same cycle SHALL cancel: value unchanged, no flag pulse.
REQ-023 Digit values SHALL never leave 0..BASE-1.
REQ-024 Scan divider counts 0..SCAN_DIV-1. At terminal count it returns to 0 and the scan index advances by 1, wrapping from DIGITS-1 to 0.
REQ-025 digit_select SHALL be exactly one-hot at all times; digit SHALL be a combinational function of the registered scan index and value.

Reset
REQ-026 With reset high at a rising edge, the following SHALL apply at that edge:
- value = 0, overflow = 0, underflow = 0.
- scan index = 0 (digit_select = 1), divider = 0.
- synchronizer and previous-level registers = 1 (released).
- repeat counters cleared.
A button held through reset SHALL generate no event until it is released and pressed again. Reset SHALL override any simultaneous event.

Configuration
REQ-027 With macro DIGIT_COUNTER_AUTOREPEAT_EN defined, a button continuously pressed for REPEAT_DELAY cycles after its press event SHALL generate one further event. It SHALL then generate one event every REPEAT_PERIOD cycles until release. Repeat events obey REQ-018..REQ-022. Without the macro, each press yields exactly one event, and REPEAT_DELAY and REPEAT_PERIOD are ignored.

Verification
(All scenarios use DIGITS=4, BASE=10, SCAN_DIV=4 unless stated.)
REQ-028 Reset, then 3 increase presses -> value = 0x0003; each update occurs on edge 3 after the press; no flags.
REQ-029 Preload value 0x0999 by presses, then 1 increase press -> value = 0x1000 (ripple carry in one cycle).
REQ-030 WRAP=1, value 0x9999, increase press -> value 0x0000 and one overflow pulse; WRAP=0 -> value stays 0x9999 and one overflow pulse.
REQ-031 Value 0x0000, decrease press -> WRAP=1 gives 0x9999 plus one underflow pulse; WRAP=0 gives 0x0000 plus one underflow pulse.
REQ-032 Both buttons pressed on the same cycle at value 0x0005 -> value 0x0005, no flags. Hold increase through reset -> value 0 with no event until release and re-press.
REQ-033 Value 0x4321, observe 16 cycles after reset -> digit_select sequence 0001, 0010, 0100, 1000, with each step held 4 cycles, and digit = 1, 2, 3, 4. With DIGIT_COUNTER_AUTOREPEAT_EN and REPEAT_DELAY=10, REPEAT_PERIOD=5, hold increase 25 cycles -> 4 increments.
